// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file and its scoreboard.
//   XLEN_DEF / NREGS_DEF : default data width and register count
//   reg_idx_t            : register index type for the default configuration
//   idx_valid()          : true when an index addresses a writable, trackable register
package regfile_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;
    localparam int unsigned IW_DEF    = $clog2(NREGS_DEF);

    typedef logic [IW_DEF-1:0] reg_idx_t;

    // Index is zero-extended by the caller so any IW can share this helper.
    function automatic logic idx_valid(input logic [31:0] idx,
                                       input int unsigned nregs,
                                       input logic        zero_reg);
        return (idx < nregs) && !(zero_reg && (idx == '0));
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
//   clk, reset  : rising-edge clock, asynchronous active-high reset
//   wr_ok       : per-port write strobe, already qualified by index validity
//   wr_idx      : packed per-port write index
//   iss_valid   : an instruction issued that will write iss_rd
//   iss_rd      : destination of the issued instruction
//   busy_vec    : current busy bits
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS    = NREGS_DEF,
    parameter int unsigned NWR      = 2,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned IW      = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NWR-1:0]    wr_ok,
    input  logic [NWR*IW-1:0] wr_idx,
    input  logic              iss_valid,
    input  logic [IW-1:0]     iss_rd,
    output logic [NREGS-1:0]  busy_vec
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Clears are applied first so a same-cycle issue to the same register
    // overrides them: the newly issued producer is still outstanding.
    always_comb begin
        busy_d = busy_q;
        for (int unsigned k = 0; k < NWR; k++) begin
            if (wr_ok[k]) begin
                busy_d[wr_idx[k*IW +: IW]] = 1'b0;
            end
        end
        if (iss_valid && idx_valid(32'(iss_rd), NREGS, ZERO_REG != 0)) begin
            busy_d[iss_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with integrated pending-write scoreboard.
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   wr_en/wr_idx/wr_data: NWR write ports, highest port index wins on conflict
//   iss_valid/iss_rd    : issue notification, marks iss_rd busy
//   rd_en/rd_idx        : NRD read ports
//   rd_data/rd_busy     : combinational read data and operand-pending flags
//   busy_vec            : raw scoreboard state
//   dbg_idx/dbg_data    : debug read tap, independent of rd_en
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned NREGS    = NREGS_DEF,
    parameter int unsigned NRD      = 2,
    parameter int unsigned NWR      = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1,
    localparam int unsigned IW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*IW-1:0]   wr_idx,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_valid,
    input  logic [IW-1:0]       iss_rd,
    input  logic [NRD-1:0]      rd_en,
    input  logic [NRD*IW-1:0]   rd_idx,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    output logic [NREGS-1:0]    busy_vec,
    input  logic [IW-1:0]       dbg_idx,
    output logic [XLEN-1:0]     dbg_data
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [NWR-1:0]  wr_ok;

    always_comb begin
        for (int unsigned k = 0; k < NWR; k++) begin
            wr_ok[k] = wr_en[k] && idx_valid(32'(wr_idx[k*IW +: IW]), NREGS, ZERO_REG != 0);
        end
    end

    // Ascending port order lets the highest-index port overwrite lower ones.
    always_comb begin
        regs_d = regs_q;
        for (int unsigned k = 0; k < NWR; k++) begin
            if (wr_ok[k]) begin
                regs_d[wr_idx[k*IW +: IW]] = wr_data[k*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .wr_ok     (wr_ok),
        .wr_idx    (wr_idx),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .busy_vec  (busy_vec)
    );

    // Reads are gated by reset as well, since the bypass path would otherwise
    // forward write data presented while reset is held.
    always_comb begin
        logic [IW-1:0]   idx;
        logic [XLEN-1:0] val;
        logic            hit;
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            idx = rd_idx[i*IW +: IW];
            val = '0;
            hit = 1'b0;
            if (!reset && rd_en[i] && idx_valid(32'(idx), NREGS, ZERO_REG != 0)) begin
                val = regs_q[idx];
                if (BYPASS != 0) begin
                    for (int unsigned k = 0; k < NWR; k++) begin
                        if (wr_ok[k] && (wr_idx[k*IW +: IW] == idx)) begin
                            hit = 1'b1;
                            val = wr_data[k*XLEN +: XLEN];
                        end
                    end
                end
                rd_data[i*XLEN +: XLEN] = val;
                rd_busy[i]              = busy_vec[idx] && !hit;
            end
        end
    end

    always_comb begin
        dbg_data = '0;
        if (!reset && (32'(dbg_idx) < NREGS)) begin
            dbg_data = regs_q[dbg_idx];
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
module tb_regfile_mp_sb;

    logic clk;
    logic reset;

    // Default configuration: 32 regs, 2 read, 2 write ports
    logic [1:0]  wr_en;
    logic [9:0]  wr_idx;
    logic [63:0] wr_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [1:0]  rd_en;
    logic [9:0]  rd_idx;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [31:0] busy_vec;
    logic [4:0]  dbg_idx;
    logic [31:0] dbg_data;

    // Non-power-of-2 configuration: 24 regs, 3 read, 2 write ports
    logic [1:0]  s_wr_en;
    logic [9:0]  s_wr_idx;
    logic [63:0] s_wr_data;
    logic        s_iss_valid;
    logic [4:0]  s_iss_rd;
    logic [2:0]  s_rd_en;
    logic [14:0] s_rd_idx;
    logic [95:0] s_rd_data;
    logic [2:0]  s_rd_busy;
    logic [23:0] s_busy_vec;
    logic [4:0]  s_dbg_idx;
    logic [31:0] s_dbg_data;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    regfile_mp_sb u_dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .rd_en     (rd_en),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .busy_vec  (busy_vec),
        .dbg_idx   (dbg_idx),
        .dbg_data  (dbg_data)
    );

    regfile_mp_sb #(
        .NREGS (24),
        .NRD   (3),
        .NWR   (2)
    ) u_small (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (s_wr_en),
        .wr_idx    (s_wr_idx),
        .wr_data   (s_wr_data),
        .iss_valid (s_iss_valid),
        .iss_rd    (s_iss_rd),
        .rd_en     (s_rd_en),
        .rd_idx    (s_rd_idx),
        .rd_data   (s_rd_data),
        .rd_busy   (s_rd_busy),
        .busy_vec  (s_busy_vec),
        .dbg_idx   (s_dbg_idx),
        .dbg_data  (s_dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = '0; wr_idx = '0; wr_data = '0;
        iss_valid = 1'b0; iss_rd = '0;
        rd_en = '0; rd_idx = '0; dbg_idx = '0;
        s_wr_en = '0; s_wr_idx = '0; s_wr_data = '0;
        s_iss_valid = 1'b0; s_iss_rd = '0;
        s_rd_en = '0; s_rd_idx = '0; s_dbg_idx = '0;
    endtask

    task automatic set_wr(input int p, input logic [4:0] idx, input logic [31:0] d);
        wr_en[p]          = 1'b1;
        wr_idx[p*5 +: 5]  = idx;
        wr_data[p*32 +: 32] = d;
    endtask

    task automatic set_rd(input int p, input logic [4:0] idx);
        rd_en[p]         = 1'b1;
        rd_idx[p*5 +: 5] = idx;
    endtask

    task automatic s_set_wr(input int p, input logic [4:0] idx, input logic [31:0] d);
        s_wr_en[p]            = 1'b1;
        s_wr_idx[p*5 +: 5]    = idx;
        s_wr_data[p*32 +: 32] = d;
    endtask

    task automatic s_set_rd(input int p, input logic [4:0] idx);
        s_rd_en[p]         = 1'b1;
        s_rd_idx[p*5 +: 5] = idx;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        set_rd(0, 5'd1);
        dbg_idx = 5'd1;
        #2;
        check("reset_rd0", 64'(rd_data[31:0]), 64'h0);
        check("reset_busy_vec", 64'(busy_vec), 64'h0);
        check("reset_dbg", 64'(dbg_data), 64'h0);
        tick();
        tick();
        idle();
        reset = 1'b0;

        // ---- 1. load r1..r31 with i*0x11, busy on r5, then reset mid-write
        for (int i = 1; i < 32; i++) begin
            set_wr(0, 5'(i), 32'(i * 17));
            tick();
        end
        idle();
        iss_valid = 1'b1; iss_rd = 5'd5;
        tick();
        idle();
        set_rd(0, 5'd1); set_rd(1, 5'd31); dbg_idx = 5'd16;
        #1;
        check("load_r1", 64'(rd_data[31:0]), 64'h11);
        check("load_r31", 64'(rd_data[63:32]), 64'h20f);
        check("load_busy_vec", 64'(busy_vec), 64'h20);
        check("load_dbg_r16", 64'(dbg_data), 64'h110);
        idle();
        set_rd(0, 5'd5);
        #1;
        check("r5_busy", 64'(rd_busy[0]), 64'h1);
        check("r5_data", 64'(rd_data[31:0]), 64'h55);
        idle();
        set_rd(0, 5'd1); set_rd(1, 5'd2); dbg_idx = 5'd31;
        set_wr(0, 5'd2, 32'hBEEF);
        iss_valid = 1'b1; iss_rd = 5'd6;
        #1;
        check("pre_reset_bypass", 64'(rd_data[63:32]), 64'hbeef);
        reset = 1'b1;
        #1;
        check("mid_reset_rd0", 64'(rd_data[31:0]), 64'h0);
        check("mid_reset_rd1", 64'(rd_data[63:32]), 64'h0);
        check("mid_reset_busy_vec", 64'(busy_vec), 64'h0);
        check("mid_reset_dbg", 64'(dbg_data), 64'h0);
        tick();
        check("held_reset_rd1", 64'(rd_data[63:32]), 64'h0);
        check("held_reset_busy_vec", 64'(busy_vec), 64'h0);
        idle();
        reset = 1'b0;
        set_rd(0, 5'd1); set_rd(1, 5'd2); dbg_idx = 5'd31;
        #1;
        check("post_reset_r1", 64'(rd_data[31:0]), 64'h0);
        check("post_reset_r2", 64'(rd_data[63:32]), 64'h0);
        check("post_reset_r31_dbg", 64'(dbg_data), 64'h0);
        check("post_reset_busy_vec", 64'(busy_vec), 64'h0);

        // ---- 2. zero register
        idle();
        set_wr(0, 5'd0, 32'hDEADBEEF);
        iss_valid = 1'b1; iss_rd = 5'd0;
        set_rd(0, 5'd0);
        #1;
        check("r0_same_cycle", 64'(rd_data[31:0]), 64'h0);
        check("r0_same_busy", 64'(rd_busy[0]), 64'h0);
        tick();
        idle();
        set_rd(0, 5'd0); dbg_idx = 5'd0;
        #1;
        check("r0_read", 64'(rd_data[31:0]), 64'h0);
        check("r0_busy", 64'(rd_busy[0]), 64'h0);
        check("r0_busy_vec", 64'(busy_vec[0]), 64'h0);
        check("r0_dbg", 64'(dbg_data), 64'h0);

        // ---- 3. write-port conflict on r7
        idle();
        set_wr(0, 5'd7, 32'hAAAA0000);
        set_wr(1, 5'd7, 32'h5555FFFF);
        set_rd(0, 5'd7);
        #1;
        check("conflict_bypass", 64'(rd_data[31:0]), 64'h5555ffff);
        tick();
        idle();
        set_rd(0, 5'd7); dbg_idx = 5'd7;
        #1;
        check("conflict_read", 64'(rd_data[31:0]), 64'h5555ffff);
        check("conflict_dbg", 64'(dbg_data), 64'h5555ffff);
        check("write_nonbusy_busy_vec", 64'(busy_vec), 64'h0);
        rd_en = '0;
        #1;
        check("rd_en_off", 64'(rd_data[31:0]), 64'h0);

        // ---- 4. bypass clears pending operand
        idle();
        iss_valid = 1'b1; iss_rd = 5'd3;
        tick();
        idle();
        set_rd(1, 5'd3);
        #1;
        check("r3_busy", 64'(rd_busy[1]), 64'h1);
        check("r3_busy_vec", 64'(busy_vec), 64'h8);
        set_wr(1, 5'd3, 32'h1234);
        #1;
        check("r3_bypass_data", 64'(rd_data[63:32]), 64'h1234);
        check("r3_bypass_busy", 64'(rd_busy[1]), 64'h0);
        tick();
        idle();
        set_rd(1, 5'd3);
        #1;
        check("r3_busy_vec_after", 64'(busy_vec[3]), 64'h0);
        check("r3_read_after", 64'(rd_data[63:32]), 64'h1234);

        // ---- 5. set-over-clear, and no counting on re-issue
        idle();
        set_wr(0, 5'd9, 32'h99);
        iss_valid = 1'b1; iss_rd = 5'd9;
        tick();
        idle();
        set_rd(0, 5'd9);
        #1;
        check("r9_set_wins", 64'(busy_vec[9]), 64'h1);
        check("r9_data", 64'(rd_data[31:0]), 64'h99);
        check("r9_rd_busy", 64'(rd_busy[0]), 64'h1);
        idle();
        iss_valid = 1'b1; iss_rd = 5'd10;
        tick();
        tick();
        idle();
        set_wr(1, 5'd10, 32'h10);
        set_wr(0, 5'd9, 32'h98);
        tick();
        idle();
        #1;
        check("reissue_single_clear", 64'(busy_vec), 64'h0);

        // ---- 6. non-power-of-2 instance
        idle();
        s_set_wr(0, 5'd1, 32'h101);
        s_set_wr(1, 5'd2, 32'h202);
        tick();
        idle();
        s_set_wr(0, 5'd23, 32'h2323);
        s_set_wr(1, 5'd30, 32'hFFFFFFFF);
        s_iss_valid = 1'b1; s_iss_rd = 5'd30;
        s_set_rd(0, 5'd30);
        #1;
        check("s_idx30_same_cycle", 64'(s_rd_data[31:0]), 64'h0);
        tick();
        idle();
        s_set_rd(0, 5'd30); s_dbg_idx = 5'd30;
        #1;
        check("s_idx30_read", 64'(s_rd_data[31:0]), 64'h0);
        check("s_idx30_busy", 64'(s_rd_busy[0]), 64'h0);
        check("s_idx30_dbg", 64'(s_dbg_data), 64'h0);
        check("s_busy_vec", 64'(s_busy_vec), 64'h0);
        idle();
        s_set_rd(0, 5'd1); s_set_rd(1, 5'd2); s_set_rd(2, 5'd23);
        s_dbg_idx = 5'd0;
        #1;
        check("s_r1", 64'(s_rd_data[31:0]), 64'h101);
        check("s_r2", 64'(s_rd_data[63:32]), 64'h202);
        check("s_r23", 64'(s_rd_data[95:64]), 64'h2323);
        check("s_r0_dbg", 64'(s_dbg_data), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
